// File: rtl/pw_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pw_tx_arbiter
//
// Purpose:
//   Shares one pulse-width coded serial line between two byte producers.
//   A round-robin arbiter picks a producer while the line is idle. The granted
//   byte is then sent LSB first. Each bit is a space (txd = 0) whose length
//   gives the bit value, followed by a fixed-length mark (txd = 1).
//
// Parameters:
//   ZERO_LEN  space length in clocks for a 0 bit (legal 2..7)
//   ONE_LEN   space length in clocks for a 1 bit (legal 11..15)
//   GAP_LEN   mark length in clocks after every bit (at least 20)
//
// Ports:
//   clock         system clock, all logic on the rising edge
//   reset_        synchronous, active-low reset
//   req0, req1    producer requests, held with stable data until acked
//   data0, data1  bytes offered by producer 0 / 1
//   ack0, ack1    one-cycle pulse when the producer's byte has been latched
//   txd           serial line, 1 = mark, 0 = space
//   busy          high for every cycle of a byte transmission
//   gnt           index of the producer being served (or last served)
// ---------------------------------------------------------------------------
module pw_tx_arbiter #(
    parameter int ZERO_LEN = 4,
    parameter int ONE_LEN  = 13,
    parameter int GAP_LEN  = 20
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       txd,
    output logic       busy,
    output logic       gnt
);

    // Line states: waiting for a request, driving a space, driving a mark.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPACE = 2'd1,
        MARK  = 2'd2
    } txState_t;

    txState_t   state_q,  state_d;
    logic [7:0] sh_q,     sh_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] cnt_q,    cnt_d;
    logic       rr_q,     rr_d;
    logic       gnt_q,    gnt_d;
    logic       txd_q,    txd_d;
    logic       busy_q,   busy_d;
    logic       ack0_q,   ack0_d;
    logic       ack1_q,   ack1_d;

    logic       grantIdx;
    logic [7:0] grantByte;

    // The pulse counter counts down to zero, so it is loaded with one less
    // than the number of cycles the pulse must last.
    function automatic logic [7:0] spaceLoad(input logic bitVal);
        return bitVal ? 8'(ONE_LEN - 1) : 8'(ZERO_LEN - 1);
    endfunction

    localparam logic [7:0] GapLoad = 8'(GAP_LEN - 1);

    // State register: every piece of state, including the registered line
    // outputs, updates here. Reset forces an idle, marking line and abandons
    // any partly sent byte.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q  <= IDLE;
            sh_q     <= 8'd0;
            bitCnt_q <= 3'd0;
            cnt_q    <= 8'd0;
            rr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitCnt_q <= bitCnt_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    // Arbitration: a lone request wins outright; when both producers ask,
    // the round-robin pointer decides. Only meaningful in IDLE.
    always_comb begin
        grantIdx = 1'b0;
        if (req0 && req1) begin
            grantIdx = rr_q;
        end else if (req1) begin
            grantIdx = 1'b1;
        end
        grantByte = grantIdx ? data1 : data0;
    end

    // Next-state logic. Acks default low so each one lasts a single cycle.
    // The line value for the coming cycle is decided together with the state
    // change, so txd switches on exactly the edge that enters SPACE or MARK.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitCnt_d = bitCnt_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (req0 || req1) begin
                    rr_d     = ~grantIdx;
                    gnt_d    = grantIdx;
                    sh_d     = grantByte;
                    bitCnt_d = 3'd0;
                    cnt_d    = spaceLoad(grantByte[0]);
                    ack0_d   = ~grantIdx;
                    ack1_d   = grantIdx;
                    busy_d   = 1'b1;
                    txd_d    = 1'b0;
                    state_d  = SPACE;
                end
            end

            SPACE: begin
                if (cnt_q == 8'd0) begin
                    txd_d   = 1'b1;
                    cnt_d   = GapLoad;
                    state_d = MARK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            MARK: begin
                if (cnt_q == 8'd0) begin
                    if (bitCnt_q == 3'd7) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // sh[1] is the bit that moves into position 0.
                        sh_d     = {1'b0, sh_q[7:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                        cnt_d    = spaceLoad(sh_q[1]);
                        txd_d    = 1'b0;
                        state_d  = SPACE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers, so the line never glitches.
    always_comb begin
        txd  = txd_q;
        busy = busy_q;
        gnt  = gnt_q;
        ack0 = ack0_q;
        ack1 = ack1_q;
    end

endmodule
